// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two valid/ready
// requesters. One transaction at a time: IDLE (arbitrate/accept) -> EXEC
// (ALU settles on registered operands, result captured) -> RESP (result held
// until the owner takes it).
// Optional build macro: ARB_ROUND_ROBIN_EN selects round-robin tie-breaking;
// without it requester 0 has fixed priority.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [OP_WIDTH-1:0]   req0_op,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [OP_WIDTH-1:0]   req1_op,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero,
  output logic [OP_WIDTH-1:0]   alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  output logic                  busy,
  output logic                  grant_id
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   gnt0, gnt1;
  logic   accept;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  // tie goes to the requester that did not win last time
  always_comb begin
    gnt0 = req0_valid & (~req1_valid | last_grant);
    gnt1 = req1_valid & (~req0_valid | ~last_grant);
  end

  // remember the most recent winner; reset value lets requester 0 win first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      last_grant <= 1'b1;
    else if (accept) last_grant <= gnt1;
  end
`else
  // fixed priority: requester 0 always wins a tie
  always_comb begin
    gnt0 = req0_valid;
    gnt1 = req1_valid & ~req0_valid;
  end
`endif

  assign accept = (state == IDLE) & (req0_valid | req1_valid);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state and handshake outputs; ready is masked while reset is held
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        req0_ready = gnt0 & reset;
        req1_ready = gnt1 & reset;
        if (accept) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp0_valid = ~grant_id;
        rsp1_valid = grant_id;
        if (grant_id ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // operand latch on accept (held otherwise so the ALU never toggles),
  // result capture at the end of EXEC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      grant_id   <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      if (accept) begin
        alu_op   <= gnt1 ? req1_op : req0_op;
        alu_a    <= gnt1 ? req1_a  : req0_a;
        alu_b    <= gnt1 ? req1_b  : req0_b;
        grant_id <= gnt1;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a transaction-level reference model checked
// against the DUT on every falling edge, directed scenarios with literal
// expectations, then a randomized soak. Honours ARB_ROUND_ROBIN_EN.
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int OW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic [OW-1:0] req0_op = 0, req1_op = 0;
  logic [DW-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, busy, grant_id;
  logic [DW-1:0] rsp_result, alu_a, alu_b, alu_result;
  logic [OW-1:0] alu_op;
  logic          alu_zero;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .grant_id(grant_id)
  );

  // the shared ALU itself
  function automatic logic [DW-1:0] alu_fn(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~(a | b);
      3'd3: return a + b;
      3'd4: return a - b;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // who wins among the valid requesters (-1: nobody)
  function automatic int winner(input logic v0, input logic v1, input logic lg);
    if (v0 && v1) begin
`ifdef ARB_ROUND_ROBIN_EN
      return lg ? 0 : 1;
`else
      return 0;
`endif
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // reference model: phase 0 waiting, 1 computing, 2 result offered
  int            m_phase;
  logic          m_owner, m_lg, m_zero;
  logic [OW-1:0] m_op;
  logic [DW-1:0] m_a, m_b, m_res;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= 0; m_owner <= 0; m_lg <= 1; m_op <= 0; m_a <= 0; m_b <= 0; m_res <= 0; m_zero <= 0;
    end else if (m_phase == 0) begin
      if (winner(req0_valid, req1_valid, m_lg) == 0) begin
        m_phase <= 1; m_owner <= 0; m_lg <= 0; m_op <= req0_op; m_a <= req0_a; m_b <= req0_b;
      end else if (winner(req0_valid, req1_valid, m_lg) == 1) begin
        m_phase <= 1; m_owner <= 1; m_lg <= 1; m_op <= req1_op; m_a <= req1_a; m_b <= req1_b;
      end
    end else if (m_phase == 1) begin
      m_res   <= alu_fn(m_op, m_a, m_b);
      m_zero  <= (alu_fn(m_op, m_a, m_b) == '0);
      m_phase <= 2;
    end else if (m_owner ? rsp1_ready : rsp0_ready) begin
      m_phase <= 0;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    chk("req0_ready", req0_ready, reset && m_phase == 0 && winner(req0_valid, req1_valid, m_lg) == 0);
    chk("req1_ready", req1_ready, reset && m_phase == 0 && winner(req0_valid, req1_valid, m_lg) == 1);
    chk("rsp0_valid", rsp0_valid, m_phase == 2 && !m_owner);
    chk("rsp1_valid", rsp1_valid, m_phase == 2 && m_owner);
    chk("busy", busy, m_phase != 0);
    chk("grant_id", grant_id, m_owner);
    chk("alu_op", alu_op, m_op);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("rsp_result", rsp_result, m_res);
    chk("rsp_zero", rsp_zero, m_zero);
  end

  // response handshake log
  int          hs_id[$];
  logic [31:0] hs_res[$];
  always @(negedge clk)
    if (reset && ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))) begin
      hs_id.push_back(int'(grant_id));
      hs_res.push_back(rsp_result);
    end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // present a request and hold it until accepted
  task automatic send(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic got;
    got = 0;
    if (id == 0) begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    else         begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = (id == 0) ? req0_ready : req1_ready;
    end
    if (!got) chk("accept_timeout", 0, 1);
    step();
    if (id == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  // count falling edges until the response shows up
  task automatic wait_rsp(input int id, output int lat);
    logic seen;
    seen = 0;
    lat = 0;
    while (!seen && lat < 50) begin
      @(negedge clk);
      lat++;
      seen = (id == 0) ? rsp0_valid : rsp1_valid;
    end
    if (!seen) chk("rsp_timeout", 0, 1);
  endtask

  int          lat;
  int          e_id[3];
  logic [31:0] e_res[3];

  initial begin
    #1 reset = 0;
    #7;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_grant_id", grant_id, 0);
    #15 reset = 1;
    step();
    rsp0_ready = 1; rsp1_ready = 1;

    // ADD 5+7 from requester 0
    send(0, 3'd3, 5, 7);
    wait_rsp(0, lat);
    chk("t1_latency", lat, 2);
    chk("t1_result", rsp_result, 12);
    chk("t1_zero", rsp_zero, 0);
    chk("t1_rsp1_valid", rsp1_valid, 0);
    step();

    // SUB 9-9 from requester 1
    send(1, 3'd4, 9, 9);
    chk("t2_grant_exec", grant_id, 1);
    wait_rsp(1, lat);
    chk("t2_result", rsp_result, 0);
    chk("t2_zero", rsp_zero, 1);
    chk("t2_grant_resp", grant_id, 1);
    chk("t2_rsp0_valid", rsp0_valid, 0);
    step();

    // three back-to-back ties: requester 0 NOR 0/0, requester 1 OR 3/4
    hs_id.delete(); hs_res.delete();
    req0_valid = 1; req0_op = 3'd2; req0_a = 0; req0_b = 0;
    req1_valid = 1; req1_op = 3'd1; req1_a = 3; req1_b = 4;
    for (int i = 0; i < 100 && hs_id.size() < 3; i++) @(posedge clk);
    #1 req0_valid = 0; req1_valid = 0;
    if (hs_id.size() < 3) chk("t3_timeout", hs_id.size(), 3);
    else begin
`ifdef ARB_ROUND_ROBIN_EN
      e_id[0] = 0; e_id[1] = 1; e_id[2] = 0;
      e_res[0] = 32'hFFFF_FFFF; e_res[1] = 32'd7; e_res[2] = 32'hFFFF_FFFF;
`else
      e_id[0] = 0; e_id[1] = 0; e_id[2] = 0;
      e_res[0] = 32'hFFFF_FFFF; e_res[1] = 32'hFFFF_FFFF; e_res[2] = 32'hFFFF_FFFF;
`endif
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("t3_grant%0d", i), hs_id[i], e_id[i]);
        chk($sformatf("t3_result%0d", i), hs_res[i], e_res[i]);
      end
    end
    repeat (3) step();

    // response back-pressure: ADD 1+1 held for 5 cycles, requester 1 waiting
    rsp0_ready = 0; rsp1_ready = 0;
    send(0, 3'd3, 1, 1);
    req1_valid = 1; req1_op = 3'd0; req1_a = 32'hFF; req1_b = 32'h0F;
    wait_rsp(0, lat);
    chk("t4_latency", lat, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_rsp0_hold", rsp0_valid, 1);
      chk("t4_result_hold", rsp_result, 2);
      chk("t4_req1_blocked", req1_ready, 0);
    end
    step();
    rsp0_ready = 1;
    @(negedge clk);
    chk("t4_req1_hs_cycle", req1_ready, 0);
    @(negedge clk);
    chk("t4_req1_after_hs", req1_ready, 1);
    step();
    req1_valid = 0; rsp1_ready = 1;
    wait_rsp(1, lat);
    chk("t4_req1_result", rsp_result, 32'h0F);
    step();

    // reset in the middle of EXEC
    send(0, 3'd0, 32'hF0, 32'h3C);
    #2 reset = 0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_alu_op", alu_op, 0);
    chk("t5_alu_a", alu_a, 0);
    chk("t5_alu_b", alu_b, 0);
    chk("t5_rsp0_valid", rsp0_valid, 0);
    chk("t5_rsp_result", rsp_result, 0);
    chk("t5_grant_id", grant_id, 0);
    @(posedge clk); @(posedge clk);
    #3 reset = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", rsp0_valid | rsp1_valid, 0);
    end
    step();
    send(1, 3'd3, 2, 3);
    wait_rsp(1, lat);
    chk("t5_after_reset", rsp_result, 5);
    step();

    // undefined op passes through, ALU yields zero
    send(0, 3'b110, 8, 1);
    chk("t6_alu_op", alu_op, 3'b110);
    wait_rsp(0, lat);
    chk("t6_result", rsp_result, 0);
    chk("t6_zero", rsp_zero, 1);
    step(); step();
    chk("t6_idle", busy, 0);

    // randomized soak, checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      req0_valid = $urandom_range(0, 1);
      req1_valid = $urandom_range(0, 1);
      req0_op = OW'($urandom_range(0, 7));
      req1_op = OW'($urandom_range(0, 7));
      req0_a = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : $urandom;
      req0_b = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : $urandom;
      req1_a = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : $urandom;
      req1_b = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : $urandom;
      rsp0_ready = ($urandom_range(0, 9) < 7);
      rsp1_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    repeat (6) step();
    chk("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
